// File: rtl/csr_pkg.sv
// csr_pkg: definitions shared between the SPI command sequencer and the
// CSR register file.
//   - CSR_ADDR_W   : default CSR address width
//   - CMD_*        : bit positions and codes within the SPI command byte
//   - seq_state_t  : sequencer FSM state encoding
//   - status_byte(): MISO status byte presented while idle
package csr_pkg;

   localparam int CSR_ADDR_W = 4;

   // Command byte: [7]=write, [6]=auto-increment, [5:4]=11 clears err,
   // [3:0]=start address.
   localparam int         CMD_WR_BIT = 7;
   localparam int         CMD_AI_BIT = 6;
   localparam int         CMD_CLR_HI = 5;
   localparam int         CMD_CLR_LO = 4;
   localparam logic [1:0] CMD_CLR    = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WR_DATA,
      ST_RD_ISSUE,
      ST_RD_CAPTURE,
      ST_RD_HOLD,
      ST_ABORT
   } seq_state_t;

   // {err, busy_at_entry, 2'b00, frame_cnt[3:0]}; busy_at_entry is always 0
   // because the byte is only loaded while idle.
   function automatic logic [7:0] status_byte(input logic err, input logic [3:0] cnt_lo);
      return {err, 1'b0, 2'b00, cnt_lo};
   endfunction

endpackage

// File: rtl/gap_timer.sv
// gap_timer: 8-bit inter-byte gap counter.
//   sys_clk, rst : clock, synchronous active-low reset
//   clr          : restart the count from zero (wins over en)
//   en           : count this cycle
//   tc           : high in the cycle whose count step reaches TC
module gap_timer #(
   parameter int TC = 255
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [7:0] cnt;

   always_ff @(posedge sys_clk) begin
      if (!rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && cnt != 8'(TC))
         cnt <= cnt + 8'd1;
   end

   // Flag the step that lands on TC so the owner can react on that same edge.
   assign tc = en && (cnt == 8'(TC - 1));

endmodule

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: turns SPI frames (command byte + data bytes) into
// single-cycle CSR write/read strobes and stages MISO bytes.
//   sys_clk, rst       : clock, synchronous active-low reset
//   ss                 : SPI select (active low, synchronised)
//   rx_byte, rx_rdy    : received byte and its one-cycle valid pulse
//   tx_latch           : slave has taken tx_byte
//   tx_byte            : next MISO byte (status while idle, read data otherwise)
//   csr_addr/wdata/we  : CSR write port
//   csr_re, csr_rdata  : CSR read strobe, data valid the cycle after the strobe
//   busy, err          : not idle, sticky error (byte-gap timeout)
//   frame_cnt          : error-free completed frames, wraps
module spi_cmd_sequencer
   import csr_pkg::*;
#(
   parameter int ADDR_W      = CSR_ADDR_W,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              ss,
   input  logic [7:0]        rx_byte,
   input  logic              rx_rdy,
   input  logic              tx_latch,
   output logic [7:0]        tx_byte,
   output logic [ADDR_W-1:0] csr_addr,
   output logic [7:0]        csr_wdata,
   output logic              csr_we,
   output logic              csr_re,
   input  logic [7:0]        csr_rdata,
   output logic              busy,
   output logic              err,
   output logic [7:0]        frame_cnt
);

   seq_state_t state;
   logic       need_release;  // block frames until ss has been seen high
   logic       ai;
   logic       cmd_rcvd;      // command byte arrived in this frame
   logic       tmo;

   // Held clear while idle so every frame starts its gap count from zero.
   gap_timer #(.TC(TIMEOUT_CYC)) u_gap (
      .sys_clk (sys_clk),
      .rst     (rst),
      .clr     (rx_rdy || state == ST_IDLE),
      .en      (!ss && state != ST_IDLE && state != ST_ABORT),
      .tc      (tmo)
   );

   assign busy = (state != ST_IDLE);

   always_ff @(posedge sys_clk) begin
      if (!rst) begin
         state        <= ST_IDLE;
         need_release <= 1'b1;
         ai           <= 1'b0;
         cmd_rcvd     <= 1'b0;
         tx_byte      <= 8'h00;
         csr_addr     <= '0;
         csr_wdata    <= 8'h00;
         csr_we       <= 1'b0;
         csr_re       <= 1'b0;
         err          <= 1'b0;
         frame_cnt    <= 8'h00;
      end else begin
         csr_we <= 1'b0;
         csr_re <= 1'b0;
         if (state == ST_IDLE) begin
            tx_byte  <= status_byte(err, frame_cnt[3:0]);
            cmd_rcvd <= 1'b0;
            if (ss)
               need_release <= 1'b0;
            else if (!need_release)
               state <= ST_CMD;
         end else if (ss) begin
            // Frame end beats any byte or latch arriving in the same cycle.
            state        <= ST_IDLE;
            need_release <= 1'b0;
            if (state != ST_ABORT && cmd_rcvd)
               frame_cnt <= frame_cnt + 8'd1;
         end else if (tmo) begin
            err   <= 1'b1;
            state <= ST_ABORT;
         end else begin
            case (state)
               ST_CMD: begin
                  if (rx_rdy) begin
                     ai       <= rx_byte[CMD_AI_BIT];
                     csr_addr <= ADDR_W'(rx_byte[3:0]);
                     cmd_rcvd <= 1'b1;
                     if (rx_byte[CMD_CLR_HI:CMD_CLR_LO] == CMD_CLR)
                        err <= 1'b0;
                     state <= rx_byte[CMD_WR_BIT] ? ST_WR_DATA : ST_RD_ISSUE;
                  end
               end
               ST_WR_DATA: begin
                  csr_we <= rx_rdy;
                  if (rx_rdy)
                     csr_wdata <= rx_byte;
                  // Advance once the strobe has been presented with the old address.
                  if (csr_we && ai)
                     csr_addr <= csr_addr + ADDR_W'(1);
               end
               ST_RD_ISSUE: begin
                  csr_re <= 1'b1;
                  state  <= ST_RD_CAPTURE;
               end
               ST_RD_CAPTURE: begin
                  // First cycle here carries the strobe; data lands on the next.
                  if (!csr_re) begin
                     tx_byte <= csr_rdata;
                     state   <= ST_RD_HOLD;
                  end
               end
               ST_RD_HOLD: begin
                  if (tx_latch) begin
                     if (ai)
                        csr_addr <= csr_addr + ADDR_W'(1);
                     state <= ST_RD_ISSUE;
                  end
               end
               ST_ABORT: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
module tb_spi_cmd_sequencer;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b0;
   logic       ss = 1'b1;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_rdy = 1'b0;
   logic       tx_latch = 1'b0;
   logic [7:0] tx_byte;
   logic [3:0] csr_addr;
   logic [7:0] csr_wdata;
   logic       csr_we;
   logic       csr_re;
   logic [7:0] csr_rdata = 8'h00;
   logic       busy;
   logic       err;
   logic [7:0] frame_cnt;

   int errors = 0;
   int checks = 0;
   int both_cnt = 0;

   logic [3:0] we_a[$];
   logic [7:0] we_d[$];
   logic [3:0] re_a[$];
   logic [7:0] mem [0:15] = '{2: 8'h5A, default: 8'h00};

   spi_cmd_sequencer #(.ADDR_W(4), .TIMEOUT_CYC(20)) dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .ss        (ss),
      .rx_byte   (rx_byte),
      .rx_rdy    (rx_rdy),
      .tx_latch  (tx_latch),
      .tx_byte   (tx_byte),
      .csr_addr  (csr_addr),
      .csr_wdata (csr_wdata),
      .csr_we    (csr_we),
      .csr_re    (csr_re),
      .csr_rdata (csr_rdata),
      .busy      (busy),
      .err       (err),
      .frame_cnt (frame_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   // CSR file model: synchronous read, data valid the cycle after csr_re.
   always @(posedge sys_clk) begin
      if (csr_we) mem[csr_addr] <= csr_wdata;
      if (csr_re) csr_rdata <= mem[csr_addr];
   end

   always @(negedge sys_clk) begin
      if (csr_we) begin
         we_a.push_back(csr_addr);
         we_d.push_back(csr_wdata);
      end
      if (csr_re) re_a.push_back(csr_addr);
      if (csr_we && csr_re) both_cnt++;
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_byte = b;
      rx_rdy  = 1'b1;
      tick();
      rx_rdy  = 1'b0;
   endtask

   task automatic frame_start();
      ss = 1'b0;
      tick(2);
   endtask

   task automatic frame_end();
      ss = 1'b1;
      tick(2);
   endtask

   task automatic clear_logs();
      we_a.delete();
      we_d.delete();
      re_a.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(2);
      checks++;
      if ({tx_byte, csr_addr, csr_wdata, csr_we, csr_re, err, frame_cnt, busy} !== 33'h0) begin
         errors++;
         $display("FAIL reset_outputs: got tx=%h a=%h d=%h we=%b re=%b err=%b cnt=%h busy=%b, want all zero",
                  tx_byte, csr_addr, csr_wdata, csr_we, csr_re, err, frame_cnt, busy);
      end
      rst = 1'b1;
      tick(2);
   endtask

   task automatic test_write_burst();
      clear_logs();
      frame_start();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
      send(8'hC3); tick(3);
      send(8'h11); tick(3);
      send(8'h22); tick(3);
      send(8'h33); tick(3);
      frame_end();
      checks++;
      if (we_a.size() !== 3 || we_a[0] !== 4'h3 || we_a[1] !== 4'h4 || we_a[2] !== 4'h5) begin
         errors++; $display("FAIL wr_addr: got n=%0d %h %h %h want 3 writes 3 4 5", we_a.size(), we_a[0], we_a[1], we_a[2]);
      end
      checks++;
      if (we_d[0] !== 8'h11 || we_d[1] !== 8'h22 || we_d[2] !== 8'h33) begin
         errors++; $display("FAIL wr_data: got %h %h %h want 11 22 33", we_d[0], we_d[1], we_d[2]);
      end
      checks++;
      if (frame_cnt !== 8'd1 || err !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL wr_end: got cnt=%0d err=%b busy=%b want 1 0 0", frame_cnt, err, busy);
      end
      checks++;
      if (tx_byte !== 8'h01) begin errors++; $display("FAIL wr_status: got %h want 01", tx_byte); end
   endtask

   task automatic test_read_no_ai();
      clear_logs();
      frame_start();
      send(8'h02);
      tick(2);
      checks++;
      if (tx_byte !== 8'h01) begin errors++; $display("FAIL rd_early: got %h want 01 (status still)", tx_byte); end
      tick();
      checks++;
      if (tx_byte !== 8'h5A) begin errors++; $display("FAIL rd_latency: got %h want 5a", tx_byte); end
      for (int k = 0; k < 2; k++) begin
         tx_latch = 1'b1; tick(); tx_latch = 1'b0;
         tick(4);
         send(8'hFF);
         tick(2);
      end
      checks++;
      if (re_a.size() !== 3 || re_a[0] !== 4'h2 || re_a[1] !== 4'h2 || re_a[2] !== 4'h2) begin
         errors++; $display("FAIL rd_strobes: got n=%0d %h %h %h want 3 reads at 2", re_a.size(), re_a[0], re_a[1], re_a[2]);
      end
      checks++;
      if (we_a.size() !== 0 || tx_byte !== 8'h5A) begin
         errors++; $display("FAIL rd_nowrite: got writes=%0d tx=%h want 0 5a", we_a.size(), tx_byte);
      end
      frame_end();
      checks++;
      if (frame_cnt !== 8'd2) begin errors++; $display("FAIL rd_cnt: got %0d want 2", frame_cnt); end
   endtask

   task automatic test_addr_wrap();
      clear_logs();
      frame_start();
      send(8'hCF); tick(3);
      send(8'hA1); tick(3);
      send(8'hA2); tick(3);
      frame_end();
      checks++;
      if (we_a.size() !== 2 || we_a[0] !== 4'hF || we_a[1] !== 4'h0 || we_d[0] !== 8'hA1 || we_d[1] !== 8'hA2) begin
         errors++; $display("FAIL wrap: got n=%0d %h:%h %h:%h want F:a1 0:a2", we_a.size(), we_a[0], we_d[0], we_a[1], we_d[1]);
      end
      checks++;
      if (frame_cnt !== 8'd3) begin errors++; $display("FAIL wrap_cnt: got %0d want 3", frame_cnt); end
   endtask

   task automatic test_timeout();
      clear_logs();
      frame_start();
      send(8'h81);
      tick(19);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL tmo_early: got err=%b want 0", err); end
      tick();
      checks++;
      if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL tmo_err: got err=%b busy=%b want 1 1", err, busy); end
      send(8'h44);
      tick(4);
      checks++;
      if (we_a.size() !== 0 || re_a.size() !== 0) begin
         errors++; $display("FAIL tmo_strobes: got we=%0d re=%0d want 0 0", we_a.size(), re_a.size());
      end
      frame_end();
      checks++;
      if (busy !== 1'b0 || frame_cnt !== 8'd3 || tx_byte !== 8'h83) begin
         errors++; $display("FAIL tmo_end: got busy=%b cnt=%0d tx=%h want 0 3 83", busy, frame_cnt, tx_byte);
      end
      frame_start();
      send(8'hB0);
      tick();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL clr_err: got %b want 0", err); end
      frame_end();
      checks++;
      if (frame_cnt !== 8'd4 || we_a.size() !== 0) begin
         errors++; $display("FAIL clr_cnt: got cnt=%0d we=%0d want 4 0", frame_cnt, we_a.size());
      end
   endtask

   task automatic test_edge_race();
      clear_logs();
      frame_start();
      send(8'hC8); tick(3);
      send(8'h55); tick(3);
      rx_byte = 8'h66; rx_rdy = 1'b1; ss = 1'b1;
      tick();
      rx_rdy = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL race_idle: got busy=%b want 0", busy); end
      tick(3);
      checks++;
      if (we_a.size() !== 1 || we_a[0] !== 4'h8 || we_d[0] !== 8'h55) begin
         errors++; $display("FAIL race_we: got n=%0d %h:%h want 1 write 8:55", we_a.size(), we_a[0], we_d[0]);
      end
      checks++;
      if (frame_cnt !== 8'd5) begin errors++; $display("FAIL race_cnt: got %0d want 5", frame_cnt); end
   endtask

   task automatic test_midframe_reset();
      frame_start();
      send(8'hC4); tick(3);
      send(8'h77); tick(3);
      rst = 1'b0;
      tick(2);
      checks++;
      if ({tx_byte, csr_addr, csr_wdata, csr_we, csr_re, err, frame_cnt, busy} !== 33'h0) begin
         errors++;
         $display("FAIL mid_reset: got tx=%h a=%h d=%h we=%b re=%b err=%b cnt=%h busy=%b, want all zero",
                  tx_byte, csr_addr, csr_wdata, csr_we, csr_re, err, frame_cnt, busy);
      end
      rst = 1'b1;
      clear_logs();
      tick();
      send(8'h84); tick(3);
      send(8'h99); tick(3);
      checks++;
      if (busy !== 1'b0 || we_a.size() !== 0) begin
         errors++; $display("FAIL mid_ignore: got busy=%b we=%0d want 0 0", busy, we_a.size());
      end
      ss = 1'b1; tick(2);
      frame_start();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL mid_rearm: got busy=%b want 1", busy); end
      send(8'h85); tick(3);
      send(8'h42); tick(3);
      frame_end();
      checks++;
      if (we_a.size() !== 1 || we_a[0] !== 4'h5 || we_d[0] !== 8'h42 || frame_cnt !== 8'd1) begin
         errors++; $display("FAIL mid_after: got n=%0d %h:%h cnt=%0d want 1 write 5:42 cnt 1",
                            we_a.size(), we_a[0], we_d[0], frame_cnt);
      end
   endtask

   task automatic test_exclusive();
      checks++;
      if (both_cnt !== 0) begin errors++; $display("FAIL we_re_overlap: got %0d cycles want 0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_read_no_ai();
      test_addr_wrap();
      test_timeout();
      test_edge_race();
      test_midframe_reset();
      test_exclusive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
